// File: rtl/icache_fetch_responder_pkg.sv
// Shared configuration for the instruction-cache fetch responder: default
// geometry, controller state encoding and the RV32C length check.
package icache_fetch_responder_pkg;

  localparam int unsigned INDEX_BITS_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2
  } fetch_state_e;

  // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input logic [15:0] half);
    return (half[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/icache_word_array.sv
// Direct-mapped word storage: valid/tag/data per index, one fill write port
// and two combinational lookup ports (word wa and its successor wa+1).
module icache_word_array
  import icache_fetch_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_en,
  input  logic [29:0] wr_wa,
  input  logic [31:0] wr_data,
  input  logic [29:0] rd0_wa,
  input  logic [29:0] rd1_wa,
  output logic        rd0_hit,
  output logic [31:0] rd0_data,
  output logic        rd1_hit,
  output logic [15:0] rd1_lo
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [DEPTH];
  logic [31:0]         data_r [DEPTH];

  logic [INDEX_BITS-1:0] wr_idx_s;
  logic [INDEX_BITS-1:0] rd0_idx_s;
  logic [INDEX_BITS-1:0] rd1_idx_s;

  assign wr_idx_s  = wr_wa[INDEX_BITS-1:0];
  assign rd0_idx_s = rd0_wa[INDEX_BITS-1:0];
  assign rd1_idx_s = rd1_wa[INDEX_BITS-1:0];

  // Valid bits: cleared by reset, set by each completed fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (en && wr_en) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless while the valid bit is 0.
  always_ff @(posedge clk) begin
    if (en && wr_en) begin
      tag_r[wr_idx_s]  <= wr_wa[29:INDEX_BITS];
      data_r[wr_idx_s] <= wr_data;
    end
  end

  assign rd0_hit  = valid_r[rd0_idx_s] && (tag_r[rd0_idx_s] == rd0_wa[29:INDEX_BITS]);
  assign rd0_data = data_r[rd0_idx_s];
  assign rd1_hit  = valid_r[rd1_idx_s] && (tag_r[rd1_idx_s] == rd1_wa[29:INDEX_BITS]);
  assign rd1_lo   = data_r[rd1_idx_s][15:0];

endmodule

// File: rtl/icache_fetch_responder.sv
// Fetch responder: looks up the requested PC in a direct-mapped word cache,
// assembles aligned, compressed and word-straddling instructions, and fills
// missing words one at a time from the memory controller.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        instr_ready_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  fetch_state_e state_r;
  logic         abort_r;
  logic [31:0]  req_pc_r;

  logic [29:0]  wa_s;
  logic [29:0]  wa_next_s;
  logic         rd0_hit_s;
  logic [31:0]  rd0_data_s;
  logic         rd1_hit_s;
  logic [15:0]  rd1_lo_s;
  logic [15:0]  lo_half_s;
  logic         need_next_s;
  logic         lookup_hit_s;
  logic [29:0]  miss_wa_s;
  logic [31:0]  lookup_instr_s;
  logic         fill_wr_s;

  // The successor word wraps within the 30-bit word address space.
  assign wa_s      = req_pc_r[31:2];
  assign wa_next_s = wa_s + 30'd1;
  assign lo_half_s = rd0_data_s[31:16];
  assign fill_wr_s = (state_r == ST_FILL) && mem_ready;

  icache_word_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_word_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (rdy),
    .wr_en    (fill_wr_s),
    .wr_wa    (mem_addr[31:2]),
    .wr_data  (mem_data),
    .rd0_wa   (wa_s),
    .rd1_wa   (wa_next_s),
    .rd0_hit  (rd0_hit_s),
    .rd0_data (rd0_data_s),
    .rd1_hit  (rd1_hit_s),
    .rd1_lo   (rd1_lo_s)
  );

  // Hit check and instruction assembly for the latched request PC.
  always_comb begin
    need_next_s    = 1'b0;
    lookup_instr_s = rd0_data_s;
    lookup_hit_s   = 1'b0;
    miss_wa_s      = wa_s;
    if (req_pc_r[1]) begin
      if (is_compressed(lo_half_s)) begin
        need_next_s    = 1'b0;
        lookup_instr_s = {16'h0000, lo_half_s};
      end else begin
        need_next_s    = 1'b1;
        lookup_instr_s = {rd1_lo_s, lo_half_s};
      end
    end else begin
      need_next_s    = 1'b0;
      lookup_instr_s = rd0_data_s;
    end
    if (!rd0_hit_s) begin
      lookup_hit_s = 1'b0;
      miss_wa_s    = wa_s;
    end else if (need_next_s && !rd1_hit_s) begin
      lookup_hit_s = 1'b0;
      miss_wa_s    = wa_next_s;
    end else begin
      lookup_hit_s = 1'b1;
      miss_wa_s    = wa_s;
    end
  end

  // Control FSM with registered fetch-side and memory-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      abort_r         <= 1'b0;
      req_pc_r        <= 32'h0000_0000;
      instr_ready_out <= 1'b0;
      instr_out       <= 32'h0000_0000;
      instr_addr_out  <= 32'h0000_0000;
      mem_req         <= 1'b0;
      mem_addr        <= 32'h0000_0000;
    end else if (rdy) begin
      instr_ready_out <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fetch_req && !rob_clear) begin
            req_pc_r <= fetch_pc;
            state_r  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (rob_clear) begin
            state_r <= ST_IDLE;
          end else if (lookup_hit_s) begin
            instr_ready_out <= 1'b1;
            instr_out       <= lookup_instr_s;
            instr_addr_out  <= req_pc_r;
            state_r         <= ST_IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {miss_wa_s, 2'b00};
            state_r  <= ST_FILL;
          end
        end
        ST_FILL: begin
          // The controller cannot cancel a fill, so a clear only marks it
          // as abandoned; the returned word is still written to the array.
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (abort_r || rob_clear) begin
              abort_r <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_LOOKUP;
            end
          end else if (rob_clear) begin
            abort_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          abort_r <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: a word-addressed memory and a
// "which word address lives at each index" cache model predict every fill
// and every returned instruction; monitors compare as the DUT presents them.
module tb_icache_fetch_responder;

  localparam int IDX = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        instr_ready_out;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;

  int errors = 0;
  int checks = 0;
  logic rdy_q = 1'b1;
  bit   rand_rdy = 1'b0;

  logic [31:0] mem_words [logic [29:0]];
  logic [29:0] cache_wa [int];
  logic [63:0] exp_q [$];
  logic [29:0] fill_q [$];

  icache_fetch_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .rob_clear       (rob_clear),
    .fetch_req       (fetch_req),
    .fetch_pc        (fetch_pc),
    .instr_ready_out (instr_ready_out),
    .instr_out       (instr_out),
    .instr_addr_out  (instr_addr_out),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_data        (mem_data)
  );

  always #5 clk = ~clk;

  // Records whether the DUT was enabled at the most recent rising edge.
  initial forever begin
    @(posedge clk);
    rdy_q = rdy;
  end

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (!mem_words.exists(wa)) mem_words[wa] = $urandom;
    return mem_words[wa];
  endfunction

  function automatic bit model_hit(input logic [29:0] wa);
    int idx;
    idx = int'(wa[IDX-1:0]);
    return cache_wa.exists(idx) && (cache_wa[idx] == wa);
  endfunction

  function automatic void model_need(input logic [29:0] wa);
    if (!model_hit(wa)) begin
      fill_q.push_back(wa);
      cache_wa[int'(wa[IDX-1:0])] = wa;
    end
  endfunction

  // Predict fills and (optionally) the returned instruction for one fetch.
  function automatic void model_fetch(input logic [31:0] pc, input bit expect_pulse);
    logic [29:0] wa;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [15:0] lo;
    logic [31:0] ins;
    wa = pc[31:2];
    model_need(wa);
    w0 = mem_word(wa);
    if (!pc[1]) begin
      ins = w0;
    end else begin
      lo = w0[31:16];
      if (lo[1:0] != 2'b11) begin
        ins = {16'h0000, lo};
      end else begin
        model_need(wa + 30'd1);
        w1 = mem_word(wa + 30'd1);
        ins = {w1[15:0], lo};
      end
    end
    if (expect_pulse) exp_q.push_back({pc, ins});
  endfunction

  // Response monitor: every fresh ready pulse must match the oldest expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_ready_out && rdy_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got pc=%h instr=%h, required no pulse",
                   instr_addr_out, instr_out);
        end else begin
          e = exp_q.pop_front();
          if (instr_addr_out !== e[63:32] || instr_out !== e[31:0]) begin
            errors++;
            $display("FAIL response: got pc=%h instr=%h, required pc=%h instr=%h",
                     instr_addr_out, instr_out, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // Memory controller model: checks fill order/stability, replies after 1-3 enabled cycles.
  initial begin
    bit          busy;
    int          cnt;
    logic [29:0] cur;
    logic [29:0] want;
    busy = 1'b0;
    cnt  = 0;
    cur  = 30'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        mem_ready = 1'b0;
      end else begin
        if (mem_ready && rdy_q) begin
          mem_ready = 1'b0;
          busy = 1'b0;
        end
        if (!busy && mem_req) begin
          checks++;
          if (fill_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_fill: got mem_addr=%h, required no mem_req", mem_addr);
          end else begin
            want = fill_q.pop_front();
            if (mem_addr !== {want, 2'b00}) begin
              errors++;
              $display("FAIL fill_addr: got %h, required %h", mem_addr, {want, 2'b00});
            end
          end
          busy = 1'b1;
          cur  = mem_addr[31:2];
          cnt  = $urandom_range(1, 3);
        end else if (busy && !mem_ready) begin
          checks++;
          if (!mem_req || mem_addr !== {cur, 2'b00}) begin
            errors++;
            $display("FAIL fill_hold: got req=%b addr=%h, required req=1 addr=%h",
                     mem_req, mem_addr, {cur, 2'b00});
          end
          if (rdy_q) cnt--;
          if (cnt <= 0) begin
            mem_ready = 1'b1;
            mem_data  = mem_word(cur);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    checks += 5;
    if (instr_ready_out !== 1'b0) begin errors++; $display("FAIL %s_ready: got %b, required 0", tag, instr_ready_out); end
    if (instr_out !== 32'h0) begin errors++; $display("FAIL %s_instr: got %h, required 0", tag, instr_out); end
    if (instr_addr_out !== 32'h0) begin errors++; $display("FAIL %s_addr: got %h, required 0", tag, instr_addr_out); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_mem_req: got %b, required 0", tag, mem_req); end
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL %s_mem_addr: got %h, required 0", tag, mem_addr); end
  endtask

  // Issue one fetch (called at a falling edge) and hold it until the pulse.
  task automatic do_fetch(input logic [31:0] pc, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    model_fetch(pc, 1'b1);
    fetch_pc  = pc;
    fetch_req = 1'b1;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (instr_ready_out && rdy_q) seen = 1'b1;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    end
    fetch_req = 1'b0;
    rdy = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no pulse for pc=%h, required a pulse", pc);
    end else if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL hit_latency: got %0d cycles, required %0d", n, exp_lat);
      end
    end
    @(negedge clk);
  endtask

  // Start a missing aligned fetch, clear it mid-fill, then request next_pc.
  task automatic do_clear(input logic [31:0] pc, input logic [31:0] next_pc);
    int n;
    n = 0;
    rdy = 1'b1;
    model_fetch(pc, 1'b0);
    fetch_pc  = pc;
    fetch_req = 1'b1;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_req) begin
      errors++;
      $display("FAIL clear_setup: got mem_req=0, required a fill for %h", pc);
    end
    rob_clear = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    rob_clear = 1'b0;
    do_fetch(next_pc, 0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] r;
    int n;

    #2_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] r;
    int n;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold aligned miss, then the hit with its fixed two-edge latency.
    mem_words[30'h0] = 32'h0050_0093;
    do_fetch(32'h0000_0000, 0);
    do_fetch(32'h0000_0000, 2);

    // Compressed instruction in the upper half: no successor word fetched.
    mem_words[30'h1] = 32'h4505_0001;
    do_fetch(32'h0000_0006, 0);

    // 32-bit instruction straddling two cold words.
    mem_words[30'h2] = 32'h0093_1234;
    mem_words[30'h3] = 32'hABCD_0050;
    do_fetch(32'h0000_000A, 0);

    // Clear during a fill; the drained word must be resident afterwards.
    do_clear(32'h0000_0100, 32'h0000_0200);
    do_clear(32'h0000_0110, 32'h0000_0110);

    // Aliasing addresses on index 0 evict each other.
    do_fetch(32'h0000_0000, 0);
    do_fetch(32'h0000_0100, 0);
    do_fetch(32'h0000_0000, 0);

    // Straddle across the top of the address space wraps to word 0.
    mem_words[30'h3FFF_FFFF] = 32'h0013_5555;
    do_fetch(32'hFFFF_FFFE, 0);

    // Reset in the middle of a fill drops it and empties the cache.
    model_fetch(32'h0000_0040, 1'b0);
    fetch_pc  = 32'h0000_0040;
    fetch_req = 1'b1;
    n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midfill_reset");
    exp_q.delete();
    fill_q.delete();
    cache_wa.delete();
    rst_n = 1'b1;
    @(negedge clk);
    do_fetch(32'h0000_0000, 0);

    // Randomized phase with rdy stalls, aliasing, straddles and clears.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FC00 | (r & 32'h0000_03FE);
      else pc = r & 32'h0000_03FE;
      if ($urandom_range(0, 7) == 0 && !model_hit(pc[31:2])) begin
        do_clear({pc[31:2], 2'b00}, pc);
      end else begin
        do_fetch(pc, 0);
      end
    end
    rand_rdy = 1'b0;
    repeat (5) @(negedge clk);

    checks++;
    if (exp_q.size() != 0 || fill_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d responses and %0d fills pending, required 0",
               exp_q.size(), fill_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
